// File: rtl/time_set_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : time_set_ctrl_if
// Purpose  : Button, running-time and edit-copy signals between the watch
//            datapath/buttons (master) and time_set_ctrl (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface time_set_ctrl_if;
   logic       tick_100hz;
   logic       btn_mode;
   logic       btn_up;
   logic       btn_down;
   logic [4:0] cur_hour;
   logic [5:0] cur_min;
   logic [5:0] cur_sec;
   logic [4:0] set_hour;
   logic [5:0] set_min;
   logic [5:0] set_sec;
   logic       set_mode;
   logic       load;
   logic [2:0] field_blank;

   modport master (
      output tick_100hz, btn_mode, btn_up, btn_down,
      output cur_hour, cur_min, cur_sec,
      input  set_hour, set_min, set_sec, set_mode, load, field_blank
   );

   modport slave (
      input  tick_100hz, btn_mode, btn_up, btn_down,
      input  cur_hour, cur_min, cur_sec,
      output set_hour, set_min, set_sec, set_mode, load, field_blank
   );
endinterface
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : time_set_ctrl
// Purpose  : Watch time-setting controller: mode/up/down editing of an
//            hour:min:sec copy, blinking field indication and commit strobe.
//            Define TIME_SET_AUTO_REPEAT_EN to enable held-button auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module time_set_ctrl #(
   parameter int REPEAT_DLY  = 50,
   parameter int REPEAT_RATE = 10,
   parameter int BLINK_HALF  = 50
) (
   input wire             clk,
   input wire             rst,
   time_set_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SET_HOUR = 3'd1,
      S_SET_MIN  = 3'd2,
      S_SET_SEC  = 3'd3,
      S_COMMIT   = 3'd4
   } state_t;

   // One width serves every tick counter in the block.
   localparam int c_TMR_MAX = (BLINK_HALF > REPEAT_DLY)
                              ? ((BLINK_HALF > REPEAT_RATE) ? BLINK_HALF : REPEAT_RATE)
                              : ((REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE);
   localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX + 1) : 1;
   localparam logic [c_TMR_W-1:0] c_TMR_ONE    = c_TMR_W'(1);
   localparam logic [c_TMR_W-1:0] c_BLINK_LAST = c_TMR_W'(BLINK_HALF - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_hist_vld;
   logic               r_mode_q;
   logic               r_up_q;
   logic               r_down_q;
   logic [c_TMR_W-1:0] r_blink_cnt;
   logic [c_TMR_W-1:0] w_blink_cnt_nxt;
   logic               r_blink_ph;
   logic               w_blink_ph_nxt;
   logic [4:0]         r_hour;
   logic [4:0]         w_hour_nxt;
   logic [5:0]         r_min;
   logic [5:0]         w_min_nxt;
   logic [5:0]         r_sec;
   logic [5:0]         w_sec_nxt;
   logic               r_set_mode;
   logic               r_load;
   logic [2:0]         r_field_blank;
   logic [2:0]         w_field_blank_nxt;

   logic w_mode_pr;
   logic w_up_pr;
   logic w_down_pr;
   logic w_in_set;
   logic w_both;
   logic w_press_step;
   logic w_step;
   logic w_step_up;

   // Presses are masked until history has been sampled once after reset, so
   // a button held through reset release is not seen as a new press.
   assign w_mode_pr = bus.btn_mode & ~r_mode_q & r_hist_vld;
   assign w_up_pr   = bus.btn_up   & ~r_up_q   & r_hist_vld;
   assign w_down_pr = bus.btn_down & ~r_down_q & r_hist_vld;

   assign w_in_set     = (r_state == S_SET_HOUR) || (r_state == S_SET_MIN) ||
                         (r_state == S_SET_SEC);
   assign w_both       = bus.btn_up & bus.btn_down;
   assign w_press_step = w_in_set & ~w_mode_pr & ~w_both & (w_up_pr | w_down_pr);

`ifdef TIME_SET_AUTO_REPEAT_EN
   localparam logic [c_TMR_W-1:0] c_DLY_LAST  = c_TMR_W'(REPEAT_DLY - 1);
   localparam logic [c_TMR_W-1:0] c_RATE_LAST = c_TMR_W'(REPEAT_RATE - 1);

   logic               r_hold_act;
   logic               r_hold_rep;
   logic               r_hold_up;
   logic [c_TMR_W-1:0] r_hold_cnt;
   logic               w_hold_ok;
   logic               w_rep_step;

   assign w_hold_ok  = w_in_set & ~w_mode_pr & ~w_press_step &
                       (bus.btn_up ^ bus.btn_down) & r_hold_act;
   assign w_rep_step = w_hold_ok & bus.tick_100hz &
                       (r_hold_cnt == (r_hold_rep ? c_RATE_LAST : c_DLY_LAST));
   assign w_step_up  = w_press_step ? w_up_pr : r_hold_up;
   assign w_step     = w_press_step | w_rep_step;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold_act <= 1'b0;
         r_hold_rep <= 1'b0;
         r_hold_up  <= 1'b0;
         r_hold_cnt <= '0;
      end else if (w_press_step) begin
         r_hold_act <= 1'b1;
         r_hold_rep <= 1'b0;
         r_hold_up  <= w_up_pr;
         r_hold_cnt <= '0;
      end else if (!w_hold_ok) begin
         r_hold_act <= 1'b0;
         r_hold_rep <= 1'b0;
         r_hold_cnt <= '0;
      end else if (bus.tick_100hz) begin
         if (w_rep_step) begin
            r_hold_rep <= 1'b1;
            r_hold_cnt <= '0;
         end else begin
            r_hold_cnt <= r_hold_cnt + c_TMR_ONE;
         end
      end
   end
`else
   assign w_step_up = w_up_pr;
   assign w_step    = w_press_step;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (w_mode_pr) w_state_nxt = S_SET_HOUR;
         S_SET_HOUR: if (w_mode_pr) w_state_nxt = S_SET_MIN;
         S_SET_MIN:  if (w_mode_pr) w_state_nxt = S_SET_SEC;
         S_SET_SEC:  if (w_mode_pr) w_state_nxt = S_COMMIT;
         S_COMMIT:   w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_hour_nxt = r_hour;
      w_min_nxt  = r_min;
      w_sec_nxt  = r_sec;
      if (r_state == S_IDLE && w_mode_pr) begin
         w_hour_nxt = bus.cur_hour;
         w_min_nxt  = bus.cur_min;
         w_sec_nxt  = bus.cur_sec;
      end else if (w_step) begin
         case (r_state)
            S_SET_HOUR:
               if (w_step_up) w_hour_nxt = (r_hour == 5'd23) ? 5'd0  : r_hour + 5'd1;
               else           w_hour_nxt = (r_hour == 5'd0)  ? 5'd23 : r_hour - 5'd1;
            S_SET_MIN:
               if (w_step_up) w_min_nxt = (r_min == 6'd59) ? 6'd0  : r_min + 6'd1;
               else           w_min_nxt = (r_min == 6'd0)  ? 6'd59 : r_min - 6'd1;
            S_SET_SEC:
               if (w_step_up) w_sec_nxt = (r_sec == 6'd59) ? 6'd0  : r_sec + 6'd1;
               else           w_sec_nxt = (r_sec == 6'd0)  ? 6'd59 : r_sec - 6'd1;
            default: ;
         endcase
      end
   end

   // Any state change or step restarts blinking in the visible phase so the
   // edited digit is shown immediately.
   always_comb begin
      w_blink_cnt_nxt = r_blink_cnt;
      w_blink_ph_nxt  = r_blink_ph;
      if ((w_state_nxt != r_state) || w_step) begin
         w_blink_cnt_nxt = '0;
         w_blink_ph_nxt  = 1'b0;
      end else if (bus.tick_100hz) begin
         if (r_blink_cnt == c_BLINK_LAST) begin
            w_blink_cnt_nxt = '0;
            w_blink_ph_nxt  = ~r_blink_ph;
         end else begin
            w_blink_cnt_nxt = r_blink_cnt + c_TMR_ONE;
         end
      end
   end

   always_comb begin
      w_field_blank_nxt = 3'b000;
      case (w_state_nxt)
         S_SET_HOUR: w_field_blank_nxt = {w_blink_ph_nxt, 2'b00};
         S_SET_MIN:  w_field_blank_nxt = {1'b0, w_blink_ph_nxt, 1'b0};
         S_SET_SEC:  w_field_blank_nxt = {2'b00, w_blink_ph_nxt};
         default:    w_field_blank_nxt = 3'b000;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_hist_vld    <= 1'b0;
         r_mode_q      <= 1'b0;
         r_up_q        <= 1'b0;
         r_down_q      <= 1'b0;
         r_blink_cnt   <= '0;
         r_blink_ph    <= 1'b0;
         r_hour        <= 5'd0;
         r_min         <= 6'd0;
         r_sec         <= 6'd0;
         r_set_mode    <= 1'b0;
         r_load        <= 1'b0;
         r_field_blank <= 3'b000;
      end else begin
         r_state       <= w_state_nxt;
         r_hist_vld    <= 1'b1;
         r_mode_q      <= bus.btn_mode;
         r_up_q        <= bus.btn_up;
         r_down_q      <= bus.btn_down;
         r_blink_cnt   <= w_blink_cnt_nxt;
         r_blink_ph    <= w_blink_ph_nxt;
         r_hour        <= w_hour_nxt;
         r_min         <= w_min_nxt;
         r_sec         <= w_sec_nxt;
         r_set_mode    <= (w_state_nxt != S_IDLE);
         r_load        <= (w_state_nxt == S_COMMIT);
         r_field_blank <= w_field_blank_nxt;
      end
   end

   assign bus.set_hour    = r_hour;
   assign bus.set_min     = r_min;
   assign bus.set_sec     = r_sec;
   assign bus.set_mode    = r_set_mode;
   assign bus.load        = r_load;
   assign bus.field_blank = r_field_blank;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_set_ctrl
// Purpose  : Self-checking bench for time_set_ctrl: vector table, directed
//            corner sequences and randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_set_ctrl;
   localparam int BH   = 50;
   localparam int DLY  = 50;
   localparam int RATE = 10;
`ifdef TIME_SET_AUTO_REPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   time_set_ctrl_if bus();

   time_set_ctrl #(
      .REPEAT_DLY  (DLY),
      .REPEAT_RATE (RATE),
      .BLINK_HALF  (BH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: state 0=IDLE 1=HOUR 2=MIN 3=SEC 4=COMMIT.
   int m_st, m_h, m_m, m_s, m_blink_t, m_hold_t;
   bit m_pm, m_pu, m_pd, m_arm, m_hold_on, m_hold_up;
   int cur_h, cur_m, cur_s;

   task automatic model_reset();
      m_st = 0; m_h = 0; m_m = 0; m_s = 0; m_blink_t = 0; m_hold_t = 0;
      m_pm = 0; m_pu = 0; m_pd = 0; m_arm = 0; m_hold_on = 0; m_hold_up = 0;
   endtask

   task automatic model_clk(input bit m, input bit u, input bit d, input bit t);
      bit mp, upp, dnp, in_set, press_step, step, dir_up, hold_ok;
      int nxt, delta;
      mp  = m && !m_pm && m_arm;
      upp = u && !m_pu && m_arm;
      dnp = d && !m_pd && m_arm;
      in_set = (m_st >= 1) && (m_st <= 3);
      nxt = (m_st == 4) ? 0 : (mp ? m_st + 1 : m_st);
      press_step = in_set && !mp && !(u && d) && (upp || dnp);
      step = press_step;
      dir_up = upp;
      hold_ok = in_set && !mp && (u != d) && m_hold_on;
      if (press_step) begin
         m_hold_on = 1; m_hold_up = upp; m_hold_t = 0;
      end else if (!hold_ok) begin
         m_hold_on = 0; m_hold_t = 0;
      end else if (t) begin
         m_hold_t++;
         if (AR && (m_hold_t == DLY || (m_hold_t > DLY && (m_hold_t - DLY) % RATE == 0))) begin
            step = 1;
            dir_up = m_hold_up;
         end
      end
      if (m_st == 0 && mp) begin
         m_h = cur_h; m_m = cur_m; m_s = cur_s;
      end
      if (step) begin
         delta = dir_up ? 1 : -1;
         case (m_st)
            1: m_h = (m_h + 24 + delta) % 24;
            2: m_m = (m_m + 60 + delta) % 60;
            3: m_s = (m_s + 60 + delta) % 60;
            default: ;
         endcase
      end
      if (nxt != m_st || step) m_blink_t = 0;
      else if (t) m_blink_t++;
      m_st = nxt; m_pm = m; m_pu = u; m_pd = d; m_arm = 1;
   endtask

   function automatic logic [21:0] model_out();
      logic [2:0] fb;
      fb = 3'b000;
      if (((m_blink_t / BH) % 2) == 1) begin
         case (m_st)
            1: fb = 3'b100;
            2: fb = 3'b010;
            3: fb = 3'b001;
            default: fb = 3'b000;
         endcase
      end
      return {5'(m_h), 6'(m_m), 6'(m_s), (m_st != 0), (m_st == 4), fb};
   endfunction

   function automatic logic [21:0] dut_out();
      return {bus.set_hour, bus.set_min, bus.set_sec, bus.set_mode, bus.load, bus.field_blank};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic set_cur(input int h, input int m, input int s);
      cur_h = h; cur_m = m; cur_s = s;
      bus.cur_hour = 5'(h); bus.cur_min = 6'(m); bus.cur_sec = 6'(s);
   endtask

   task automatic cyc(input bit m, input bit u, input bit d, input bit t);
      bus.btn_mode = m; bus.btn_up = u; bus.btn_down = d; bus.tick_100hz = t;
      @(posedge clk);
      model_clk(m, u, d, t);
      #1;
      check("model", 32'(dut_out()), 32'(model_out()));
   endtask

   task automatic do_reset(input bit hold_mode);
      bus.btn_mode = hold_mode; bus.btn_up = 0; bus.btn_down = 0; bus.tick_100hz = 0;
      rst = 1'b1;
      #2;
      model_reset();
      check("reset_async", 32'(dut_out()), 32'd0);
      @(posedge clk);
      #1;
      check("reset_hold", 32'(dut_out()), 32'd0);
      rst = 1'b0;
   endtask

   task automatic press_mode();
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
   endtask

   typedef struct {
      bit         mode, up, down;
      logic [4:0] eh;
      logic [5:0] em, es;
      logic       esm, eld;
      logic [2:0] efb;
   } vec_t;

   vec_t tbl[11];

   initial begin
      bit rm, ru, rd;
      tbl[0]  = '{0, 0, 0, 5'd0,  6'd0,  6'd0,  0, 0, 3'b000};
      tbl[1]  = '{1, 0, 0, 5'd12, 6'd34, 6'd56, 1, 0, 3'b000};
      tbl[2]  = '{0, 0, 0, 5'd12, 6'd34, 6'd56, 1, 0, 3'b000};
      tbl[3]  = '{1, 0, 0, 5'd12, 6'd34, 6'd56, 1, 0, 3'b000};
      tbl[4]  = '{0, 0, 0, 5'd12, 6'd34, 6'd56, 1, 0, 3'b000};
      tbl[5]  = '{1, 0, 0, 5'd12, 6'd34, 6'd56, 1, 0, 3'b000};
      tbl[6]  = '{0, 0, 0, 5'd12, 6'd34, 6'd56, 1, 0, 3'b000};
      tbl[7]  = '{1, 0, 0, 5'd12, 6'd34, 6'd56, 1, 1, 3'b000};
      tbl[8]  = '{0, 0, 0, 5'd12, 6'd34, 6'd56, 0, 0, 3'b000};
      tbl[9]  = '{0, 1, 0, 5'd12, 6'd34, 6'd56, 0, 0, 3'b000};
      tbl[10] = '{0, 0, 0, 5'd12, 6'd34, 6'd56, 0, 0, 3'b000};

      set_cur(12, 34, 56);
      #1;
      do_reset(0);
      for (int i = 0; i < 11; i++) begin
         cyc(tbl[i].mode, tbl[i].up, tbl[i].down, 0);
         check($sformatf("table[%0d]", i), 32'(dut_out()),
               32'({tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].esm, tbl[i].eld, tbl[i].efb}));
      end

      // Wrap-around of hour up and minute down.
      do_reset(0);
      cyc(0, 0, 0, 0);
      set_cur(23, 0, 0);
      press_mode();
      cyc(0, 1, 0, 0);
      check("hour_wrap_up", 32'(bus.set_hour), 32'd0);
      cyc(0, 0, 0, 0);
      press_mode();
      cyc(0, 0, 1, 0);
      check("min_wrap_down", 32'(bus.set_min), 32'd59);
      cyc(0, 0, 0, 0);

      // Blinking in SET_HOUR and simultaneous up/down.
      do_reset(0);
      cyc(0, 0, 0, 0);
      set_cur(5, 6, 7);
      press_mode();
      check("blink_start", 32'(bus.field_blank), 32'd0);
      for (int k = 1; k <= 200; k++) begin
         cyc(0, 0, 0, 1);
         if (k % 25 == 0)
            check($sformatf("blink_tick%0d", k), 32'(bus.field_blank),
                  ((k / 50) % 2 == 1) ? 32'b100 : 32'b000);
         cyc(0, 0, 0, 0);
      end
      cyc(0, 1, 1, 0);
      check("both_no_step", 32'(bus.set_hour), 32'd5);
      cyc(0, 0, 0, 0);

      // Holding up for 100 ticks in SET_SEC.
      do_reset(0);
      cyc(0, 0, 0, 0);
      set_cur(0, 0, 0);
      press_mode(); press_mode(); press_mode();
      cyc(0, 1, 0, 0);
      for (int k = 0; k < 100; k++) begin
         cyc(0, 1, 0, 1);
         cyc(0, 1, 0, 0);
      end
      check("hold_sec", 32'(bus.set_sec), AR ? 32'd7 : 32'd1);
      cyc(0, 0, 0, 0);

      // Reset mid-edit discards the copy and never loads.
      do_reset(0);
      cyc(0, 0, 0, 0);
      set_cur(10, 20, 30);
      press_mode();
      cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
      press_mode();
      cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
      check("edit_before_rst", 32'({bus.set_hour, bus.set_min}), 32'({5'd11, 6'd21}));
      do_reset(0);
      for (int k = 0; k < 10; k++) begin
         cyc(0, 0, 0, 1);
         check("no_load_after_rst", 32'(bus.load), 32'd0);
      end
      check("idle_after_rst", 32'(dut_out()), 32'd0);

      // Button held through reset release is not a press.
      do_reset(1);
      cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
      check("held_thru_rst", 32'(bus.set_mode), 32'd0);
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      check("repress_after_rst", 32'(bus.set_mode), 32'd1);

      // Randomized traffic.
      rm = 1; ru = 0; rd = 0;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 59) == 0) rm = ~rm;
         if ($urandom_range(0, 29) == 0) ru = ~ru;
         if ($urandom_range(0, 29) == 0) rd = ~rd;
         if ($urandom_range(0, 199) == 0)
            set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
         if ($urandom_range(0, 1999) == 0) begin
            ru = 0; rd = 0;
            do_reset(rm);
         end
         cyc(rm, ru, rd, $urandom_range(0, 1) == 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter REPEAT_DLY, default 50, meaning tick_100hz pulses a button is held before the first auto-repeat step.
REQ-002 SHALL have parameter REPEAT_RATE, default 10, meaning tick_100hz pulses between successive auto-repeat steps.
REQ-003 SHALL have parameter BLINK_HALF, default 50, meaning tick_100hz pulses per blink half-period.
REQ-004 SHALL have port clk, input, 1: system clock, 100 MHz; all state is updated on the rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port tick_100hz, input, 1: single-cycle 100 Hz timing strobe.
REQ-007 SHALL have ports btn_mode, btn_up and btn_down, input, 1 each: debounced, clk-synchronous button levels, 1 = pressed.
REQ-008 SHALL have ports cur_hour (5), cur_min (6) and cur_sec (6), input: running time from the watch datapath.
REQ-009 SHALL have ports set_hour (5), set_min (6) and set_sec (6), output: edit-copy values.
REQ-010 SHALL have port set_mode, output, 1: high in every state except IDLE.
REQ-011 SHALL have port load, output, 1: single-cycle commit strobe to the watch datapath.
REQ-012 SHALL have port field_blank, output, 3: bits {hour, min, sec}; 1 = blank that display field.

Function
REQ-013 SHALL define a press as btn=1 while the internally registered previous value of that button is 0; the resulting action SHALL be visible at the same clk edge.
REQ-014 SHALL implement FSM states IDLE, SET_HOUR, SET_MIN, SET_SEC and COMMIT.
REQ-015 SHALL, on a btn_mode press, transition IDLE->SET_HOUR, SET_HOUR->SET_MIN, SET_MIN->SET_SEC and SET_SEC->COMMIT.
REQ-016 SHALL always transition COMMIT->IDLE after exactly one cycle.
REQ-017 SHALL, on the IDLE->SET_HOUR transition, capture cur_hour, cur_min and cur_sec into set_hour, set_min and set_sec.
REQ-018 SHALL, while in IDLE, hold set_hour, set_min and set_sec at their last values.
REQ-019 SHALL assert load only during COMMIT, for exactly 1 cycle, with set_* stable during that cycle.
REQ-020 SHALL, on a btn_up press in SET_x, increment the selected field modulo its range: hour 0..23, min 0..59, sec 0..59 (23->0, 59->0).
REQ-021 SHALL, on a btn_down press in SET_x, decrement the selected field modulo its range (0->23 for hour, 0->59 for min and sec).
REQ-022 SHALL, when btn_up and btn_down are both 1 in the same cycle, make no step and clear the hold counter.
REQ-023 SHALL ignore btn_up and btn_down in IDLE and COMMIT.
REQ-024 SHALL give btn_mode priority when btn_mode and btn_up/btn_down press in the same cycle: the state advances and no step is made.
REQ-025 SHALL keep a blink counter on tick_100hz that toggles the blink phase every BLINK_HALF ticks.
REQ-026 SHALL set the selected field's field_blank bit only during the blank phase; all other field_blank bits SHALL be 0.
REQ-027 SHALL restart the blink counter in the visible phase on every state change and on every step.
REQ-028 SHALL drive field_blank=000 in IDLE and COMMIT.
REQ-029 SHALL count tick_100hz pulses only, never raw clk cycles, for all timing.

Reset
REQ-030 SHALL, on rst, asynchronously force state=IDLE, set_hour=0, set_min=0, set_sec=0, set_mode=0, load=0, field_blank=000, and clear all counters and button history.
REQ-031 SHALL, on a reset asserted mid-edit, generate no load and discard the edit copy.
REQ-032 SHALL treat a button held through reset release as already pressed: no press is detected until it is released and pressed again.

Configuration
REQ-033 SHALL, with macro TIME_SET_AUTO_REPEAT_EN defined, make the first extra step after REPEAT_DLY ticks of an uninterrupted hold of one direction button in SET_x, then one step every REPEAT_RATE ticks until release.
REQ-034 SHALL, with TIME_SET_AUTO_REPEAT_EN undefined, make exactly one step per press, with no hold counter present.

Verification
REQ-035 SHALL cover: with cur=12:34:56, press btn_mode 4 times -> states SET_HOUR, SET_MIN, SET_SEC, then load=1 for 1 cycle with set=12:34:56, then IDLE.
REQ-036 SHALL cover: in SET_HOUR at 23, press btn_up -> 0; in SET_MIN at 0, press btn_down -> 59.
REQ-037 SHALL cover: with macro defined, hold btn_up 100 ticks in SET_SEC from 0 -> 1 + 1 + 5 steps, ending at set_sec=7.
REQ-038 SHALL cover: with macro undefined, run the same stimulus as REQ-037 -> set_sec=1.
REQ-039 SHALL cover: assert rst in SET_MIN after edits -> load never asserted, all outputs 0, state IDLE.
REQ-040 SHALL cover: in SET_HOUR with no button activity for 200 ticks -> field_blank toggles 100/000 every 50 ticks, starting visible; btn_up and btn_down pressed in the same cycle -> no change to set_hour.
